// File: rtl/comparator_v.sv
// comparator_v - vertical-timing decoder for the VGA controller.
//
// Decodes the vertical line counter into a combinational sync level and a
// set of registered vertical-timing qualifiers for the pixel/colour pipeline.
//
// Parameters
//   N            : countV width is N+1 bits (first parameter, so #(7) gives 8 bits)
//   SYNC_LINES   : sync pulse length in lines at start of frame
//   BACK_PORCH   : lines between sync and active video
//   ACTIVE_LINES : visible lines
//   FRONT_PORCH  : lines after active video
//   SYNC_POL     : level of sync during the pulse (0 = active-low)
//
// Ports
//   clk         in   1     system clock
//   rst         in   1     synchronous active-high reset
//   countV      in   N+1   current vertical line number, 0-based
//   sync        out  1     vertical sync, combinational from countV
//   sync_q      out  1     sync registered
//   video_on_v  out  1     registered vertical active-video flag
//   row         out  N+1   registered active row index (0 outside active video)
//   frame_start out  1     one-cycle pulse on a nonzero->0 countV transition
//   frame_cnt   out  16    registered count of frames since reset (wraps)
//   range_err   out  1     sticky: countV >= TOTAL seen since reset
module comparator_v #(
  parameter int unsigned N            = 9,
  parameter int unsigned SYNC_LINES   = 2,
  parameter int unsigned BACK_PORCH   = 33,
  parameter int unsigned ACTIVE_LINES = 480,
  parameter int unsigned FRONT_PORCH  = 10,
  parameter logic        SYNC_POL     = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:0]   countV,
  output logic         sync,
  output logic         sync_q,
  output logic         video_on_v,
  output logic [N:0]   row,
  output logic         frame_start,
  output logic [15:0]  frame_cnt,
  output logic         range_err
);

  localparam int unsigned W           = N + 1;
  localparam int unsigned V_ACT_START = SYNC_LINES + BACK_PORCH;
  localparam int unsigned V_ACT_END   = V_ACT_START + ACTIVE_LINES;
  localparam int unsigned TOTAL       = V_ACT_END + FRONT_PORCH;

  // Zero-extended so that constants wider than the counter compare correctly;
  // regions beyond the counter's reach simply never match.
  logic [31:0] cnt_ext;
  assign cnt_ext = 32'(countV);

  logic         sync_d,      sync_r_q;
  logic         video_on_d,  video_on_q;
  logic [W-1:0] row_d,       row_q;
  logic         frame_st_d,  frame_st_q;
  logic [15:0]  frame_cnt_d, frame_cnt_q;
  logic         range_err_d, range_err_q;
  logic [W-1:0] prev_d,      prev_q;

  always_comb begin
    sync_d      = (cnt_ext < SYNC_LINES) ? SYNC_POL : ~SYNC_POL;
    video_on_d  = (cnt_ext >= V_ACT_START) && (cnt_ext < V_ACT_END);
    row_d       = video_on_d ? W'(cnt_ext - V_ACT_START) : '0;
    // prev resets to 0, so the first 0 after reset never produces a pulse.
    frame_st_d  = (countV == '0) && (prev_q != '0);
    frame_cnt_d = frame_cnt_q + 16'(frame_st_d);
    range_err_d = range_err_q | (cnt_ext >= TOTAL);
    prev_d      = countV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r_q    <= ~SYNC_POL;
      video_on_q  <= 1'b0;
      row_q       <= '0;
      frame_st_q  <= 1'b0;
      frame_cnt_q <= '0;
      range_err_q <= 1'b0;
      prev_q      <= '0;
    end else begin
      sync_r_q    <= sync_d;
      video_on_q  <= video_on_d;
      row_q       <= row_d;
      frame_st_q  <= frame_st_d;
      frame_cnt_q <= frame_cnt_d;
      range_err_q <= range_err_d;
      prev_q      <= prev_d;
    end
  end

  assign sync        = sync_d;
  assign sync_q      = sync_r_q;
  assign video_on_v  = video_on_q;
  assign row         = row_q;
  assign frame_start = frame_st_q;
  assign frame_cnt   = frame_cnt_q;
  assign range_err   = range_err_q;

endmodule

// File: tb/tb_comparator_v.sv
module tb_comparator_v;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  countV = '0;
  logic        sync, sync_q, video_on_v, frame_start, range_err;
  logic [9:0]  row;
  logic [15:0] frame_cnt;

  // 8-bit instance for the combinational sync check; never clocked.
  logic        clk_s = 1'b0;
  logic        rst_s = 1'b0;
  logic [7:0]  countV_s = '0;
  logic        sync_s, sync_q_s, von_s, fs_s, err_s;
  logic [7:0]  row_s;
  logic [15:0] fcnt_s;

  int checks = 0;
  int errors = 0;

  // Reference model state (default timing: 2 sync, active 35..514, total 525)
  int          m_prev;
  int          m_sync_q, m_von, m_row, m_fs, m_err;
  int unsigned m_fcnt;

  always #5 clk = ~clk;

  comparator_v dut (
    .clk(clk), .rst(rst), .countV(countV), .sync(sync), .sync_q(sync_q),
    .video_on_v(video_on_v), .row(row), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .range_err(range_err)
  );

  comparator_v #(7) u_small (
    .clk(clk_s), .rst(rst_s), .countV(countV_s), .sync(sync_s), .sync_q(sync_q_s),
    .video_on_v(von_s), .row(row_s), .frame_start(fs_s),
    .frame_cnt(fcnt_s), .range_err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("sync_q", {31'd0, sync_q}, m_sync_q);
    chk("video_on_v", {31'd0, video_on_v}, m_von);
    chk("row", {22'd0, row}, m_row);
    chk("frame_start", {31'd0, frame_start}, m_fs);
    chk("frame_cnt", {16'd0, frame_cnt}, m_fcnt);
    chk("range_err", {31'd0, range_err}, m_err);
  endtask

  // Drive one line value (and reset), check sync combinationally, clock it,
  // update the model from the timing rules and check the registered outputs.
  task automatic step(input int v, input bit r);
    countV = 10'(v);
    rst    = r;
    #1;
    chk("sync", {31'd0, sync}, (v < 2) ? 0 : 1);
    @(posedge clk);
    if (r) begin
      m_sync_q = 1; m_von = 0; m_row = 0; m_fs = 0; m_fcnt = 0; m_err = 0;
      m_prev = 0;
    end else begin
      m_sync_q = (v < 2) ? 0 : 1;
      m_von    = (v >= 35 && v < 515) ? 1 : 0;
      m_row    = m_von ? v - 35 : 0;
      m_fs     = (v == 0 && m_prev != 0) ? 1 : 0;
      if (m_fs) m_fcnt = (m_fcnt + 1) % 65536;
      if (v >= 525) m_err = 1;
      m_prev = v;
    end
    #1;
    check_regs();
  endtask

  initial begin
    m_prev = 0; m_sync_q = 1; m_von = 0; m_row = 0; m_fs = 0; m_fcnt = 0; m_err = 0;

    // 8-bit instance: combinational sync only
    countV_s = 8'd0;  #10; chk("small_sync_0",  {31'd0, sync_s}, 0);
    countV_s = 8'd1;  #10; chk("small_sync_1",  {31'd0, sync_s}, 0);
    countV_s = 8'd30; #10; chk("small_sync_30", {31'd0, sync_s}, 1);

    @(negedge clk);
    // Reset, then hold 0: no frame event
    step(0, 1'b1);
    chk("rst_sync_q", {31'd0, sync_q}, 1);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 0);
    chk("rst_range_err", {31'd0, range_err}, 0);
    chk("rst_video_on", {31'd0, video_on_v}, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0);
      chk("hold0_no_fs", {31'd0, frame_start}, 0);
    end

    // Full sweep, then wrap twice
    for (int v = 0; v < 525; v++) begin
      step(v, 1'b0);
      if (v == 35)  chk("row_at_35", {22'd0, row}, 0);
      if (v == 35)  chk("von_at_35", {31'd0, video_on_v}, 1);
      if (v == 514) chk("row_at_514", {22'd0, row}, 479);
      if (v == 515) chk("von_at_515", {31'd0, video_on_v}, 0);
      if (v == 1)   chk("sync_q_at_1", {31'd0, sync_q}, 0);
      if (v == 2)   chk("sync_q_at_2", {31'd0, sync_q}, 1);
    end
    step(0, 1'b0);
    chk("wrap1_fs", {31'd0, frame_start}, 1);
    chk("wrap1_cnt", {16'd0, frame_cnt}, 1);
    step(0, 1'b0);
    chk("wrap1_single", {31'd0, frame_start}, 0);
    for (int v = 1; v < 525; v++) step(v, 1'b0);
    step(0, 1'b0);
    chk("wrap2_fs", {31'd0, frame_start}, 1);
    chk("wrap2_cnt", {16'd0, frame_cnt}, 2);
    step(1, 1'b0);
    chk("wrap2_single", {31'd0, frame_start}, 0);

    // Out-of-range is sticky
    step(600, 1'b0);
    chk("range_set", {31'd0, range_err}, 1);
    for (int v = 10; v < 20; v++) step(v, 1'b0);
    chk("range_sticky", {31'd0, range_err}, 1);
    step(524, 1'b0);
    step(525, 1'b0);

    // Mid-frame reset
    step(200, 1'b1);
    chk("midrst_err", {31'd0, range_err}, 0);
    chk("midrst_cnt", {16'd0, frame_cnt}, 0);
    chk("midrst_von", {31'd0, video_on_v}, 0);
    step(100, 1'b0);
    step(0, 1'b0);
    chk("midrst_fs", {31'd0, frame_start}, 1);
    chk("midrst_fcnt", {16'd0, frame_cnt}, 1);

    // Random lines, occasional zeros and resets
    for (int i = 0; i < 600; i++) begin
      int v;
      v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 540));
      step(v, ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_v.md
# comparator_v

Vertical-timing decoder for the VGA controller. It takes the vertical line counter `countV` and produces:
- the vertical sync level, combinationally;
- registered vertical-timing qualifiers: active-video flag, active row index, frame-start pulse, frame counter and a sticky out-of-range flag.

It sits between the vertical line counter and the pixel/colour pipeline.

## Interface
Parameters:
- `N`, default 9: `countV` width is N+1 bits. Must be the first parameter, so `#(7)` positional override selects an 8-bit counter.
- `SYNC_LINES`, default 2: lines of sync pulse at the start of frame.
- `BACK_PORCH`, default 33: lines after sync before active video.
- `ACTIVE_LINES`, default 480: visible lines.
- `FRONT_PORCH`, default 10: lines after active video.
- `SYNC_POL`, default 0: level of `sync` during the pulse (0 = active-low).

Ports:
- `clk`, input, 1: system clock. One clock only.
- `rst`, input, 1: reset. Synchronous, active-high.
- `countV`, input, N+1: current vertical line number, 0-based.
- `sync`, output, 1: vertical sync, combinational from `countV`.
- `sync_q`, output, 1: `sync` registered.
- `video_on_v`, output, 1: registered vertical active-video flag.
- `row`, output, N+1: registered active row index.
- `frame_start`, output, 1: one-cycle pulse at frame wrap.
- `frame_cnt`, output, 16: registered count of frames since reset.
- `range_err`, output, 1: sticky flag, `countV` ≥ TOTAL seen.

## Operation
- Derived constants:
  - V_ACT_START = SYNC_LINES + BACK_PORCH.
  - V_ACT_END = V_ACT_START + ACTIVE_LINES.
  - TOTAL = V_ACT_END + FRONT_PORCH (525 by default).
- All comparisons are unsigned. `countV` is zero-extended to 32 bits, so constants wider than the counter never truncate. Unreachable regions simply never assert.
- `sync` is purely combinational, with no dependence on `clk`/`rst`:
  - `sync` = SYNC_POL when `countV` < SYNC_LINES;
  - otherwise `sync` = ~SYNC_POL.
  - Default: 0 for lines 0–1, 1 for lines ≥ 2.
- `video_on_v` is 1 iff V_ACT_START ≤ `countV` < V_ACT_END.
- `row` = `countV` − V_ACT_START when `video_on_v` condition holds, else 0. Width N+1; the upper bits are truncated.
- Frame start:
  - An internal register `prev` holds the previous cycle's `countV`.
  - `frame_start` = 1 for exactly one cycle when `countV` == 0 and `prev` != 0.
  - `countV` held at 0 gives a single pulse only.
- `frame_cnt` increments by 1 on every `frame_start` event and wraps from 0xFFFF to 0.
- `range_err` sets when `countV` ≥ TOTAL. It stays set until `rst`, and is not cleared by valid counts.
- No handshakes; `countV` is sampled every cycle.

## Timing
- `sync` has zero latency: it settles within the same delta/cycle as `countV`.
- Registered outputs (`sync_q`, `video_on_v`, `row`, `frame_start`, `frame_cnt`, `range_err`) reflect the `countV` sampled at the previous rising edge. Latency is 1 cycle.
- `frame_cnt` updates in the same edge that asserts `frame_start`.
- Synchronous reset, at the rising edge with `rst`=1:
  - `sync_q` = ~SYNC_POL;
  - `video_on_v` = 0, `row` = 0, `frame_start` = 0, `frame_cnt` = 0, `range_err` = 0;
  - `prev` = 0.
- Reset overrides all other updates in that cycle.
- Because `prev` resets to 0, the first `countV` = 0 after reset does not pulse `frame_start`.
- Reset mid-frame: outputs resume from the next sampled `countV`. No frame event is generated until a nonzero→0 transition is seen.
- Boundaries:
  - `countV` = SYNC_LINES−1 → sync active;
  - `countV` = SYNC_LINES → sync inactive;
  - `countV` = V_ACT_END−1 → `video_on_v` = 1, `row` = ACTIVE_LINES−1;
  - `countV` = V_ACT_END → `video_on_v` = 0.

## Test plan
- Override `#(7)`, no clock:
  - `countV` = 0 → `sync` = 0;
  - `countV` = 1 → `sync` = 0;
  - `countV` = 30 → `sync` = 1;
  - each checked 10 time units after the change.
- Defaults, reset applied:
  - after the reset edge, `sync_q` = 1, `frame_cnt` = 0, `range_err` = 0, `video_on_v` = 0;
  - `countV` = 0 held → no `frame_start`.
- Sweep `countV` 0..524 one per clock:
  - `video_on_v` rises on the cycle after `countV` = 35 and falls after 515;
  - `row` = 0 at 35 and 479 at 514;
  - `sync_q` is low only for lines 0–1, delayed by one cycle.
- Wrap 524→0 twice:
  - `frame_start` pulses exactly one cycle each time;
  - `frame_cnt` reads 1 then 2.
- `countV` = 600 for one cycle, then valid counts → `range_err` = 1 and stays 1; cleared only by `rst`.
- Assert `rst` while `countV` = 200:
  - all registered outputs return to reset values at that edge;
  - the next 0 after a nonzero count pulses `frame_start`.
